// File: rtl/umi_memtest_pkg.sv
// Shared types for the UMI memory tester: FSM states, opcodes,
// and the packet pack/unpack helpers used on the tx and rx paths.
package umi_memtest_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  localparam logic [7:0] UMI_OP_WRITE_NORMAL = 8'h01;
  localparam logic [7:0] UMI_OP_READ         = 8'h08;
  localparam int         UMI_PACKET_W        = 256;
  localparam int         UMI_DW              = 96;

  // cmd[7:0]=opcode, cmd[10:8]=size, remaining cmd bits zero
  typedef struct packed {
    logic [UMI_DW-1:0] data;
    logic [63:0]       srcaddr;
    logic [63:0]       dstaddr;
    logic [31:0]       cmd;
  } umi_pkt_t;

  function automatic logic [UMI_PACKET_W-1:0] umi_pack(
    input logic [7:0]        op,
    input logic [2:0]        size,
    input logic [63:0]       dst,
    input logic [63:0]       src,
    input logic [UMI_DW-1:0] data
  );
    umi_pkt_t p;
    p.cmd     = {21'd0, size, op};
    p.dstaddr = dst;
    p.srcaddr = src;
    p.data    = data;
    return p;
  endfunction

  function automatic umi_pkt_t umi_unpack(
    input logic [UMI_PACKET_W-1:0] pkt
  );
    return umi_pkt_t'(pkt);
  endfunction

endpackage

// File: rtl/umi_memtest_pattern.sv
// Test pattern generator: pat(a) = seed ^ zero-extended a.
// Ports: i_seed, i_addr in; o_pat out.
module umi_memtest_pattern
  import umi_memtest_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_seed,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_pat
);

  assign o_pat = i_seed ^
    {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, i_addr};

endmodule

// File: rtl/umi_memtest.sv
// UMI memory tester: writes pat(a) to every RAM word, reads each
// back and compares. Ports: clk, nreset, start, seed, umi_tx_*,
// umi_rx_*, busy, done, pass, err_count, first_err_addr.
// Option: UMI_MEMTEST_TIMEOUT_EN adds a read-response watchdog.
module umi_memtest
  import umi_memtest_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter logic [63:0] SRC_BASE   = 64'h1000_0000,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic [UMI_PACKET_W-1:0] umi_tx_packet,
  output logic                    umi_tx_valid,
  input  logic                    umi_tx_ready,
  input  logic [UMI_PACKET_W-1:0] umi_rx_packet,
  input  logic                    umi_rx_valid,
  output logic                    umi_rx_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr
);

  localparam int CW =
    (DATA_WIDTH < UMI_DW) ? DATA_WIDTH : UMI_DW;
  localparam logic [2:0] SIZE =
    3'($clog2(DATA_WIDTH/8));
  localparam logic [ADDR_WIDTH:0] LAST =
    {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                  r_state;
  logic [ADDR_WIDTH:0]     r_addr;
  logic [DATA_WIDTH-1:0]   r_seed;
  logic                    r_tx_valid;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic [15:0]             r_err;
  logic [ADDR_WIDTH-1:0]   r_first;
  logic                    r_seen;

  logic [DATA_WIDTH-1:0]   w_pat;
  logic [UMI_DW-1:0]       w_pat_ext;
  logic [63:0]             w_dst;
  logic [63:0]             w_src;
  umi_pkt_t                w_rx;
  logic                    w_tx_fire;
  logic                    w_rx_fire;
  logic                    w_last;
  logic                    w_mismatch;
  logic [15:0]             w_err_next;
  logic                    w_pass_next;
  logic                    w_unused;

  umi_memtest_pattern #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pat (
    .i_seed(r_seed),
    .i_addr(r_addr[ADDR_WIDTH-1:0]),
    .o_pat (w_pat)
  );

  assign w_dst = {{(64-ADDR_WIDTH){1'b0}},
                  r_addr[ADDR_WIDTH-1:0]};
  assign w_src = SRC_BASE | w_dst;
  assign w_rx  = umi_unpack(umi_rx_packet);

  always_comb begin
    w_pat_ext         = '0;
    w_pat_ext[CW-1:0] = w_pat[CW-1:0];
  end

  assign w_tx_fire = r_tx_valid && umi_tx_ready;
  assign w_rx_fire = umi_rx_valid &&
                     (r_state == RD_WAIT);
  assign w_last    = (r_addr == LAST);

  // response returns to our srcaddr, so check it in dstaddr
  assign w_mismatch =
    (w_rx.data[CW-1:0] != w_pat[CW-1:0]) ||
    (w_rx.dstaddr != w_src);

  assign w_err_next =
    (w_mismatch && (r_err != 16'hFFFF)) ?
    r_err + 16'd1 : r_err;

  always_comb begin
    umi_tx_packet = '0;
    if (r_tx_valid) begin
      if (r_state == WR)
        umi_tx_packet = umi_pack(UMI_OP_WRITE_NORMAL,
          SIZE, w_dst, 64'd0, w_pat_ext);
      else
        umi_tx_packet = umi_pack(UMI_OP_READ,
          SIZE, w_dst, w_src, '0);
    end
  end

`ifdef UMI_MEMTEST_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_timeout;

  assign w_pass_next = (w_err_next == 16'd0) &&
                       !r_timeout;
  assign w_unused = ^{w_rx.cmd, w_rx.srcaddr,
                      w_rx.data >> CW, w_pat >> CW};
`else
  assign w_pass_next = (w_err_next == 16'd0);
  assign w_unused = ^{w_rx.cmd, w_rx.srcaddr,
                      w_rx.data >> CW, w_pat >> CW,
                      (TIMEOUT != 0)};
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_seed     <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_first    <= '0;
      r_seen     <= 1'b0;
`ifdef UMI_MEMTEST_TIMEOUT_EN
      r_wdog     <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= WR;
            r_addr     <= '0;
            r_seed     <= seed;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_first    <= '0;
            r_seen     <= 1'b0;
`ifdef UMI_MEMTEST_TIMEOUT_EN
            r_timeout  <= 1'b0;
`endif
          end
        end
        WR: begin
          if (w_tx_fire) begin
            if (w_last) begin
              r_addr  <= '0;
              r_state <= RD_REQ;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
            r_state    <= RD_WAIT;
`ifdef UMI_MEMTEST_TIMEOUT_EN
            r_wdog     <= '0;
`endif
          end
        end
        RD_WAIT: begin
          if (w_rx_fire) begin
            r_err <= w_err_next;
            if (w_mismatch && !r_seen) begin
              r_first <= r_addr[ADDR_WIDTH-1:0];
              r_seen  <= 1'b1;
            end
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_pass_next;
            end else begin
              r_addr     <= r_addr + 1'b1;
              r_state    <= RD_REQ;
              r_tx_valid <= 1'b1;
            end
          end
`ifdef UMI_MEMTEST_TIMEOUT_EN
          else if (r_wdog == 16'(TIMEOUT-1)) begin
            r_timeout <= 1'b1;
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign umi_tx_valid   = r_tx_valid;
  assign umi_rx_ready   = (r_state == RD_WAIT);
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_first;

endmodule

// File: tb/tb_umi_memtest.sv
// Bench for umi_memtest: behavioural RAM responder plus
// table-driven and random runs with a reference result model.
module tb_umi_memtest;

  localparam int          AW  = 4;
  localparam int          DW  = 32;
  localparam int          NW  = 16;
  localparam logic [63:0] SRC = 64'h1000_0000;
  localparam int          TO  = 64;

  logic         clk = 1'b0;
  logic         nreset;
  logic         start;
  logic [31:0]  seed;
  logic [255:0] umi_tx_packet;
  logic         umi_tx_valid;
  logic         umi_tx_ready;
  logic [255:0] umi_rx_packet;
  logic         umi_rx_valid;
  logic         umi_rx_ready;
  logic         busy;
  logic         done;
  logic         pass;
  logic [15:0]  err_count;
  logic [3:0]   first_err_addr;

  umi_memtest #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SRC_BASE  (SRC),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .start         (start),
    .seed          (seed),
    .umi_tx_packet (umi_tx_packet),
    .umi_tx_valid  (umi_tx_valid),
    .umi_tx_ready  (umi_tx_ready),
    .umi_rx_packet (umi_rx_packet),
    .umi_rx_valid  (umi_rx_valid),
    .umi_rx_ready  (umi_rx_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // responder / monitor state
  logic [31:0]  mem [NW];
  int           wr_cnt, rd_cnt, rx_cnt;
  logic [31:0]  cur_seed;
  logic [15:0]  dmask, amask;
  bit           bp;
  int           drop_addr = -1;
  int           drop_cyc  = 0;
  bit           resp_pend;
  logic [255:0] resp_pkt;

  task automatic process_tx(input logic [255:0] p);
    logic [7:0]  op;
    logic [2:0]  sz;
    logic [63:0] dst, src, rdst;
    logic [31:0] dat, rdat;
    int          a;
    op  = p[7:0];
    sz  = p[10:8];
    dst = p[95:32];
    src = p[159:96];
    dat = p[191:160];
    chk("tx_size", sz, 2);
    if (op == 8'h01) begin
      chk("wr_addr", dst, wr_cnt);
      chk("wr_data", dat, cur_seed ^ 32'(wr_cnt));
      chk("wr_before_rd", rd_cnt, 0);
      mem[dst[3:0]] = dat;
      wr_cnt++;
    end else if (op == 8'h08) begin
      a = rd_cnt % NW;
      chk("rd_after_wr", wr_cnt, NW);
      chk("rd_addr", dst, rd_cnt);
      chk("rd_src", src, SRC | 64'(rd_cnt));
      chk("rd_single", resp_pend, 0);
      if (rd_cnt == drop_addr) begin
        drop_cyc = cyc;
      end else begin
        rdat = mem[dst[3:0]] ^ {31'd0, dmask[a]};
        rdst = src ^ (amask[a] ? 64'h10 : 64'h0);
        resp_pkt  = {64'd0, rdat, 64'd0, rdst, 32'd0};
        resp_pend = 1'b1;
      end
      rd_cnt++;
    end else begin
      chk("tx_opcode", op, 8'h01);
    end
  endtask

  initial begin
    bit           tx_fire, rx_fire, hold;
    logic [255:0] prev_pkt;
    tx_fire = 0; rx_fire = 0; hold = 0;
    prev_pkt = '0;
    umi_tx_ready  = 1'b0;
    umi_rx_valid  = 1'b0;
    umi_rx_packet = '0;
    resp_pend     = 1'b0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        tx_fire = 0; rx_fire = 0; hold = 0;
        resp_pend     = 1'b0;
        umi_tx_ready  = 1'b0;
        umi_rx_valid  = 1'b0;
        umi_rx_packet = '0;
        continue;
      end
      if (tx_fire) process_tx(prev_pkt);
      if (rx_fire) begin
        resp_pend    = 1'b0;
        umi_rx_valid = 1'b0;
        rx_cnt++;
      end
      if (hold) begin
        chk("tx_hold_valid", umi_tx_valid, 1);
        chk("tx_hold_pkt",
            64'(umi_tx_packet == prev_pkt), 1);
      end
      umi_tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (resp_pend && !umi_rx_valid)
        umi_rx_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      umi_rx_packet = umi_rx_valid ? resp_pkt : '0;
      tx_fire  = umi_tx_valid && umi_tx_ready;
      rx_fire  = umi_rx_valid && umi_rx_ready;
      hold     = umi_tx_valid && !umi_tx_ready;
      prev_pkt = umi_tx_packet;
    end
  end

  task automatic run_test(input logic [31:0] s,
                          input logic [15:0] dm,
                          input logic [15:0] am,
                          input bit          b,
                          input int          drop,
                          input int          mid_start,
                          output int         done_cyc);
    bit got;
    wr_cnt = 0; rd_cnt = 0; rx_cnt = 0;
    cur_seed = s; dmask = dm; amask = am;
    bp = b; drop_addr = drop;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = $urandom;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_pass", pass, 0);
    chk("start_err", err_count, 0);
    chk("start_first", first_err_addr, 0);
    got = 0;
    done_cyc = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      start = (i == mid_start);
      if (i == mid_start) seed = ~s;
      @(negedge clk);
      got = done;
    end
    start = 1'b0;
    done_cyc = cyc;
    chk("done_seen", got, 1);
    @(negedge clk);
  endtask

  task automatic check_end(input string nm,
                           input logic [15:0] e_err,
                           input logic [3:0]  e_first,
                           input bit          e_pass);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_pass"}, pass, e_pass);
    chk({nm, "_err"}, err_count, e_err);
    chk({nm, "_first"}, first_err_addr, e_first);
    chk({nm, "_writes"}, wr_cnt, NW);
    chk({nm, "_reads"}, rd_cnt, NW);
    chk({nm, "_resps"}, rx_cnt, NW);
    chk({nm, "_txv"}, umi_tx_valid, 0);
    chk({nm, "_rxr"}, umi_rx_ready, 0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_err"}, err_count, 0);
    chk({nm, "_first"}, first_err_addr, 0);
    chk({nm, "_txv"}, umi_tx_valid, 0);
    chk({nm, "_rxr"}, umi_rx_ready, 0);
    chk({nm, "_txpkt"}, 64'(umi_tx_packet == '0), 1);
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [15:0] dm;
    logic [15:0] am;
    bit          bp;
    logic [15:0] e_err;
    logic [3:0]  e_first;
    bit          e_pass;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int          dc;
    logic [31:0] s;
    logic [15:0] dm, am, m;
    logic [15:0] e_err;
    logic [3:0]  e_first;

    tbl[0] = '{32'hA5A5_0000, 16'h0000, 16'h0000,
               1'b0, 16'd0, 4'd0, 1'b1};
    tbl[1] = '{32'hA5A5_0000, 16'h0220, 16'h0000,
               1'b0, 16'd2, 4'd5, 1'b0};
    tbl[2] = '{32'h1234_5678, 16'h0000, 16'h0000,
               1'b1, 16'd0, 4'd0, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 16'h8000, 16'h0001,
               1'b1, 16'd2, 4'd0, 1'b0};
    tbl[4] = '{32'h0000_0000, 16'h0000, 16'h0100,
               1'b0, 16'd1, 4'd8, 1'b0};
    tbl[5] = '{32'h0F0F_0F0F, 16'h0006, 16'h0004,
               1'b0, 16'd2, 4'd1, 1'b0};

    nreset = 1'b0;
    start  = 1'b0;
    seed   = '0;
    bp     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    nreset = 1'b1;
    @(negedge clk);

    // directed vectors; vec2 also pulses start mid-run
    for (int i = 0; i < 6; i++) begin
      run_test(tbl[i].seed, tbl[i].dm, tbl[i].am,
               tbl[i].bp, -1, (i == 2) ? 3 : -1, dc);
      check_end($sformatf("vec%0d", i), tbl[i].e_err,
                tbl[i].e_first, tbl[i].e_pass);
    end

    // random runs against the result model
    for (int r = 0; r < 5; r++) begin
      s  = $urandom;
      dm = 16'($urandom & $urandom & $urandom);
      am = 16'($urandom & $urandom & $urandom & $urandom);
      if (r == 0) begin dm = '0; am = '0; end
      m = dm | am;
      e_err = 16'($countones(m));
      e_first = '0;
      for (int k = NW-1; k >= 0; k--)
        if (m[k]) e_first = 4'(k);
      run_test(s, dm, am, (r % 2) == 1, -1, -1, dc);
      check_end($sformatf("rnd%0d", r), e_err, e_first,
                m == 16'd0);
    end

    // reset in the middle of the read phase
    wr_cnt = 0; rd_cnt = 0; rx_cnt = 0;
    s = 32'hC3C3_1111;
    cur_seed = s; dmask = '0; amask = '0; bp = 1'b0;
    drop_addr = -1;
    seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && rd_cnt < 8; i++)
      @(negedge clk);
    chk("mid_rd7_reached", 64'(rd_cnt >= 8), 1);
    nreset = 1'b0;
    #1;
    check_reset("midrst");
    repeat (3) @(negedge clk);
    check_reset("midrst_hold");
    nreset = 1'b1;
    @(negedge clk);
    run_test(32'h5555_AAAA, '0, '0, 1'b0, -1, -1, dc);
    check_end("after_rst", 16'd0, 4'd0, 1'b1);

`ifdef UMI_MEMTEST_TIMEOUT_EN
    // response for address 3 never arrives
    run_test(32'h0BAD_F00D, '0, '0, 1'b0, 3, -1, dc);
    chk("to_done", done, 1);
    chk("to_pass", pass, 0);
    chk("to_err", err_count, 0);
    chk("to_reads", rd_cnt, 4);
    chk("to_rxr", umi_rx_ready, 0);
    chk("to_latency", dc - drop_cyc, TO);
    run_test(32'h7777_0000, '0, '0, 1'b0, -1, -1, dc);
    check_end("after_to", 16'd0, 4'd0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
